food_manager: RTL

Consumes the pseudo-random food coordinates from the food generator, validates and latches them as the on-screen food, and detects when the snake head eats the food. On a hit it pulses a new-food request to the generator, waits for both coordinates to settle, and rejects positions outside the playfield or under the head, retrying up to a bound. It also maintains the score. It sits between the food generator and the VGA renderer and game controller.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/food_manager_if.sv | 28 ++
 rtl/food_box_check.sv | 28 ++
 rtl/food_manager.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: coordinate widths, cell size, screen limits,
// food FSM states and the cell-overlap test used by the food logic.
package snake_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int CELL     = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Generator's reset position, so the first food matches the generator output.
  localparam logic [X_W-1:0] FOOD_X_RST = 10'd300;
  localparam logic [Y_W-1:0] FOOD_Y_RST = 9'd300;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK
  } food_state_e;

  // Two cells overlap when both axis distances are below one cell. The
  // differences are taken one bit wider and signed so they never wrap.
  function automatic logic cells_overlap(input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
                                         input logic [X_W-1:0] bx, input logic [Y_W-1:0] by);
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    return (dx > -11'sd8) && (dx < 11'sd8) && (dy > -10'sd8) && (dy < 10'sd8);
  endfunction

endpackage

// File: rtl/food_manager_if.sv
// Food manager bus: game/generator side is master, food_manager is slave.
interface food_manager_if;
  import snake_pkg::*;

  logic             game_tick;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [X_W-1:0]   x_box;
  logic [Y_W-1:0]   y_box;
  logic             create_new_box;
  logic [X_W-1:0]   food_x;
  logic [Y_W-1:0]   food_y;
  logic             food_valid;
  logic             eaten;
  logic             fallback_used;
  logic [15:0]      score;

  modport master (
    output game_tick, head_x, head_y, x_box, y_box,
    input  create_new_box, food_x, food_y, food_valid, eaten, fallback_used, score
  );

  modport slave (
    input  game_tick, head_x, head_y, x_box, y_box,
    output create_new_box, food_x, food_y, food_valid, eaten, fallback_used, score
  );

endinterface

// File: rtl/food_box_check.sv
// Combinational acceptance test for a food candidate: inside the legal
// playfield window and not under the snake head.
module food_box_check
  import snake_pkg::*;
#(
  parameter int X_MIN = 8,
  parameter int X_MAX = 631,
  parameter int Y_MIN = 8,
  parameter int Y_MAX = 471
) (
  input  logic [X_W-1:0] x_box,
  input  logic [Y_W-1:0] y_box,
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  output logic           accept
);

  localparam logic [X_W-1:0] XLO = X_MIN[X_W-1:0];
  localparam logic [X_W-1:0] XHI = X_MAX[X_W-1:0];
  localparam logic [Y_W-1:0] YLO = Y_MIN[Y_W-1:0];
  localparam logic [Y_W-1:0] YHI = Y_MAX[Y_W-1:0];

  logic in_range;

  assign in_range = (x_box >= XLO) && (x_box <= XHI) && (y_box >= YLO) && (y_box <= YHI);
  assign accept   = in_range && !cells_overlap(x_box, y_box, head_x, head_y);

endmodule

// File: rtl/food_manager.sv
// Food placement, hit detection and score keeping between the food generator
// and the renderer. Define FOOD_BCD_SCORE_EN for a 4-digit packed BCD score.
module food_manager
  import snake_pkg::*;
#(
  parameter int X_MIN      = 8,
  parameter int X_MAX      = 631,
  parameter int Y_MIN      = 8,
  parameter int Y_MAX      = 471,
  parameter int MAX_RETRY  = 15,
  parameter int FALLBACK_X = 320,
  parameter int FALLBACK_Y = 240
) (
  input logic          clk,
  input logic          rst_n,
  food_manager_if.slave bus
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = MAX_RETRY[RW-1:0];

  food_state_e    state, state_nxt;
  logic [RW-1:0]  retry_cnt;
  logic [X_W-1:0] food_x;
  logic [Y_W-1:0] food_y;
  logic           food_valid, eaten, fallback_used;
  logic [15:0]    score, score_inc;
  logic           hit, accept;
  logic           do_hit, do_accept, do_retry, do_fallback;

  assign hit = cells_overlap(bus.head_x, bus.head_y, food_x, food_y);

  food_box_check #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_check (
    .x_box (bus.x_box),
    .y_box (bus.y_box),
    .head_x(bus.head_x),
    .head_y(bus.head_y),
    .accept(accept)
  );

`ifdef FOOD_BCD_SCORE_EN
  // Ripple a +1 through four BCD digits; 9999 rolls over to 0000.
  function automatic logic [15:0] score_next(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction
`else
  function automatic logic [15:0] score_next(input logic [15:0] s);
    return (s == 16'hFFFF) ? s : s + 16'd1;
  endfunction
`endif

  assign score_inc = score_next(score);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    do_hit      = 1'b0;
    do_accept   = 1'b0;
    do_retry    = 1'b0;
    do_fallback = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.game_tick && food_valid && hit) begin
          do_hit    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ:  state_nxt = WAIT;
      WAIT: state_nxt = CHECK;
      CHECK: begin
        if (accept) begin
          do_accept = 1'b1;
          state_nxt = IDLE;
        end else if (retry_cnt < RETRY_LIM) begin
          do_retry  = 1'b1;
          state_nxt = REQ;
        end else begin
          do_fallback = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      retry_cnt     <= '0;
      food_x        <= FOOD_X_RST;
      food_y        <= FOOD_Y_RST;
      food_valid    <= 1'b1;
      eaten         <= 1'b0;
      fallback_used <= 1'b0;
      score         <= '0;
    end else begin
      state <= state_nxt;
      eaten <= do_hit;
      if (do_hit) begin
        score      <= score_inc;
        food_valid <= 1'b0;
        retry_cnt  <= '0;
      end
      if (do_retry) retry_cnt <= retry_cnt + 1'b1;
      if (do_accept) begin
        food_x     <= bus.x_box;
        food_y     <= bus.y_box;
        food_valid <= 1'b1;
      end
      if (do_fallback) begin
        food_x        <= FALLBACK_X[X_W-1:0];
        food_y        <= FALLBACK_Y[Y_W-1:0];
        food_valid    <= 1'b1;
        fallback_used <= 1'b1;
      end
    end
  end

  assign bus.create_new_box = (state == REQ);
  assign bus.food_x         = food_x;
  assign bus.food_y         = food_y;
  assign bus.food_valid     = food_valid;
  assign bus.eaten          = eaten;
  assign bus.fallback_used  = fallback_used;
  assign bus.score          = score;

endmodule
